rr_arbiter_8to3: RTL and testbench
==================================

// Module: rr_arbiter_8to3
// PURPOSE
//   Round-robin arbiter sharing one resource among 8 requesters.
//   Returns a registered one-hot grant plus its 3-bit binary index, for steering
//   downstream muxes and datapaths. A grant is held until its requester releases.
//   Binary index is produced by the team's one-hot-to-binary encoder function.
// PARAMETERS
//   N         8   number of requesters (fixed at 8 in this revision)
//   IDX_W     3   grant index width, clog2(N)
//   MAX_HOLD  16  max grant cycles before forced rotation (RR_ARB_TIMEOUT_EN only)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active-low
//   req        in   N      request vector; bit i = requester i wants resource
//   gnt        out  N      one-hot grant, registered
//   gnt_idx    out  IDX_W  binary index of granted requester, registered
//   gnt_valid  out  1      high when gnt holds exactly one bit
// BEHAVIOUR
//   Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
//   Reset values: gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE, ptr=0, hold_cnt=0.
//     Outputs clear immediately on rst_n fall, mid-grant included.
//   ptr = highest-priority requester. Search order: ptr, ptr+1, ..., ptr+7, mod 8.
//   Invariant: gnt_valid=1 implies gnt == (1<<gnt_idx). gnt_valid=0 implies gnt=0.
//   FSM, 2 states:
//     IDLE : req==0 -> stay. Any req -> latch winner into gnt/gnt_idx, set gnt_valid,
//            ptr<=winner+1 (7 wraps to 0), go GRANT.
//            Latency is 1 cycle from the req edge to gnt.
//     GRANT: req[gnt_idx]=1 -> hold the grant, no change.
//            req[gnt_idx]=0 and other req pending -> hand off directly to the next winner
//              (search from ptr) on the next edge. No idle cycle.
//            req[gnt_idx]=0 and no other req -> gnt=0, gnt_valid=0, go IDLE.
//   Release and new request in the same cycle: the new request is eligible now.
//   The releasing requester is lowest priority, because ptr is already past it.
//   Request that drops before it is granted: no grant, no effect on ptr.
//   Extra requests raised during GRANT have no effect until the handoff.
// CONFIGURATION
//   RR_ARB_TIMEOUT_EN defined:
//     - hold_cnt increments on each GRANT cycle and clears on every new grant.
//     - hold_cnt==MAX_HOLD-1 with another req pending -> forced handoff on the next
//       edge, even if the current req is still high. Rotation proceeds as normal.
//     - hold_cnt==MAX_HOLD-1 with no other req -> grant kept, hold_cnt saturates.
//   RR_ARB_TIMEOUT_EN undefined:
//     - no hold_cnt. A grant is held for as long as req stays high.
// STRUCTURE
//   Package arb_pkg:
//     - arb_state_t {IDLE, GRANT}
//     - localparams ARB_N=8, ARB_IDX_W=3
//     - function onehot_to_idx()
//   Sub-module rr_pick8:
//     - combinational rotate -> priority find-first -> rotate back
//     - inputs req, ptr. Outputs winner one-hot, winner idx, any.
//   Top: FSM, ptr register, output registers, optional hold counter.
// TESTING
//   1. rst_n=0 with req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0. Release reset ->
//      gnt=8'h01, idx=0 one cycle later.
//   2. From reset, req=8'b0000_0100, held 3 cycles, then 0 -> gnt=8'h04, idx=2 for
//      3 cycles, then gnt=0, valid=0.
//   3. req=8'hFF, each holder drops its bit 1 cycle after grant, then re-raises ->
//      idx sequence 0,1,2,...,7,0 back-to-back with no idle cycle.
//   4. Wrap: after a grant to 6 (ptr=7), req=8'b1000_0010 -> grant 7 first, then 1
//      after 7 releases.
//   5. RR_ARB_TIMEOUT_EN, MAX_HOLD=4, req bits 0 and 3 held high -> idx 0 for 4 cycles,
//      3 for 4 cycles, 0 again. Without the macro, idx stays 0.
//   6. rst_n pulsed low mid-GRANT (idx=5) -> outputs clear asynchronously. After
//      release with req=8'hFF, the grant goes to 0 (ptr reset).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types, sizes and helpers for the 8-way round-robin arbiter.
//   arb_state_t    : arbiter FSM state (IDLE, GRANT)
//   ARB_N          : number of requesters
//   ARB_IDX_W      : width of a requester index
//   onehot_to_idx(): one-hot to binary encoder used for the grant index
package arb_pkg;

    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // OR-reduce the indices of the set bits. For a true one-hot input this is
    // the index of that bit. An all-zero input maps to 0.
    function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_N-1:0] oh);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_N; i++) begin
            if (oh[i]) begin
                idx = idx | ARB_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_8to3_if.sv
// Request/grant bus between the requesters and the round-robin arbiter.
//   req       : requester -> arbiter, bit i = requester i wants the resource
//   gnt       : arbiter -> requester, one-hot grant (registered)
//   gnt_idx   : arbiter -> requester, binary index of the granted requester
//   gnt_valid : arbiter -> requester, high exactly when gnt has one bit set
//   state     : arbiter -> observer, current FSM state (debug visibility)
// Protocol: a requester raises req[i] and keeps it high for as long as it
// wants the resource. Once gnt[i] is seen, the grant stays in place until the
// requester drops req[i]. Dropping req[i] before it is granted withdraws the
// request with no side effects.
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_8to3_if;
    import arb_pkg::*;

    logic [ARB_N-1:0]     req;
    logic [ARB_N-1:0]     gnt;
    logic [ARB_IDX_W-1:0] gnt_idx;
    logic                 gnt_valid;
    arb_state_t           state;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  state
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output state
    );

endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin winner search over 8 requesters.
//   i_req     : request vector
//   i_ptr     : highest-priority requester index
//   o_win_oh  : one-hot winner (0 when no request)
//   o_win_idx : binary index of the winner
//   o_any     : at least one request is set
// Search order is i_ptr, i_ptr+1, ..., i_ptr+7 modulo 8.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     i_req,
    input  logic [ARB_IDX_W-1:0] i_ptr,
    output logic [ARB_N-1:0]     o_win_oh,
    output logic [ARB_IDX_W-1:0] o_win_idx,
    output logic                 o_any
);

    logic [2*ARB_N-1:0] w_rot_dbl;
    logic [ARB_N-1:0]   w_rot;
    logic [ARB_N-1:0]   w_first;
    logic [2*ARB_N-1:0] w_back_dbl;

    // Rotate right by ptr so the highest-priority requester lands on bit 0.
    assign w_rot_dbl  = {i_req, i_req} >> i_ptr;
    assign w_rot      = w_rot_dbl[ARB_N-1:0];

    // Isolate the lowest set bit: x & -x.
    assign w_first    = w_rot & (~w_rot + ARB_N'(1));

    // Rotate the single bit left by ptr to return to requester numbering.
    assign w_back_dbl = {w_first, w_first} << i_ptr;
    assign o_win_oh   = w_back_dbl[2*ARB_N-1:ARB_N];

    assign o_win_idx  = onehot_to_idx(o_win_oh);
    assign o_any      = |i_req;

endmodule

// File: rtl/rr_arbiter_8to3.sv
// Round-robin arbiter sharing one resource among 8 requesters.
// A grant is held until its requester drops its request, then handed directly
// to the next requester in round-robin order with no idle cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active-low
//   bus   : rr_arbiter_8to3_if.slave (req in; gnt, gnt_idx, gnt_valid, state out)
// Build option:
//   RR_ARB_TIMEOUT_EN : when defined, a grant held for MAX_HOLD cycles is
//   forcibly rotated to the next requester if another request is pending.
module rr_arbiter_8to3
    import arb_pkg::*;
`ifdef RR_ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 16
)
`endif
(
    input  logic               clk,
    input  logic               rst_n,
    rr_arbiter_8to3_if.slave   bus
);

    arb_state_t           r_state;
    logic [ARB_N-1:0]     r_gnt;
    logic [ARB_IDX_W-1:0] r_gnt_idx;
    logic                 r_gnt_valid;
    logic [ARB_IDX_W-1:0] r_ptr;

    logic [ARB_N-1:0]     w_win_oh;
    logic [ARB_IDX_W-1:0] w_win_idx;
    logic                 w_any;
    logic                 w_cur_req;
    logic                 w_other;
    logic                 w_handoff;

    rr_pick8 u_pick (
        .i_req     (bus.req),
        .i_ptr     (r_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx),
        .o_any     (w_any)
    );

    assign w_cur_req = bus.req[r_gnt_idx];
    // Any pending request other than the current holder. Because ptr already
    // sits past the holder, the picker returns a different requester whenever
    // this is set.
    assign w_other   = |(bus.req & ~r_gnt);

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_timeout;

    assign w_timeout = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign w_handoff = w_other & (~w_cur_req | w_timeout);
`else
    assign w_handoff = w_other & ~w_cur_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            r_hold_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt       <= w_win_oh;
                        r_gnt_idx   <= w_win_idx;
                        r_gnt_valid <= 1'b1;
                        r_ptr       <= w_win_idx + ARB_IDX_W'(1);
                        r_state     <= GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                        r_hold_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (w_handoff) begin
                        r_gnt       <= w_win_oh;
                        r_gnt_idx   <= w_win_idx;
                        r_ptr       <= w_win_idx + ARB_IDX_W'(1);
`ifdef RR_ARB_TIMEOUT_EN
                        r_hold_cnt  <= '0;
`endif
                    end else if (!w_cur_req) begin
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
`ifdef RR_ARB_TIMEOUT_EN
                        // Saturate at the limit while nobody else is waiting.
                        if (!w_timeout) begin
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_rr_arbiter_8to3.sv
// Directed bench for rr_arbiter_8to3. Inputs change 1 time unit after a
// rising edge; outputs are checked at that same point, so every check sees
// the result of the edge that just sampled the previous input values.
module tb_rr_arbiter_8to3;
    import arb_pkg::*;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    rr_arbiter_8to3_if bus ();

`ifdef RR_ARB_TIMEOUT_EN
    rr_arbiter_8to3 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`else
    rr_arbiter_8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] req_during);
        rst_n   = 1'b0;
        bus.req = req_during;
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_grant(input string tag, input int idx);
        logic [7:0] exp_oh;
        exp_oh = 8'h01 << idx;
        check_eq({tag, ".gnt"},   32'(bus.gnt),       32'(exp_oh));
        check_eq({tag, ".idx"},   32'(bus.gnt_idx),   32'(idx));
        check_eq({tag, ".valid"}, 32'(bus.gnt_valid), 32'd1);
    endtask

    task automatic check_none(input string tag);
        check_eq({tag, ".gnt"},   32'(bus.gnt),       32'd0);
        check_eq({tag, ".valid"}, 32'(bus.gnt_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        bus.req = 8'h00;

        // Reset with every requester asking: outputs stay clear.
        do_reset(8'hFF);
        check_eq("rst.gnt",   32'(bus.gnt),       32'd0);
        check_eq("rst.idx",   32'(bus.gnt_idx),   32'd0);
        check_eq("rst.valid", 32'(bus.gnt_valid), 32'd0);
        check_eq("rst.state", 32'(bus.state),     32'(IDLE));
        tick();
        check_grant("rst_rel", 0);
        check_eq("rst_rel.state", 32'(bus.state), 32'(GRANT));

        // Each holder drops its bit, everyone else stays high: 1..7 then 0.
        for (int i = 1; i <= 8; i++) begin
            bus.req = ~(8'h01 << (i - 1));
            tick();
            check_grant($sformatf("rot%0d", i), i % 8);
        end

        // Single requester 2 for three cycles, then release.
        do_reset(8'h00);
        bus.req = 8'h04;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_grant($sformatf("single%0d", c), 2);
        end
        bus.req = 8'h00;
        tick();
        check_none("single_rel");
        check_eq("single_rel.state", 32'(bus.state), 32'(IDLE));

        // Wrap: grant 6 (ptr=7), then 7 and 1 request -> 7 first.
        bus.req = 8'h40;
        tick();
        check_grant("wrap6", 6);
        bus.req = 8'b1000_0010;
        tick();
        check_grant("wrap7", 7);
        bus.req = 8'b0000_0010;
        tick();
        check_grant("wrap1", 1);

        // New request during a grant waits for the handoff.
        bus.req = 8'b0000_1010;
        tick();
        check_grant("late_hold", 1);
        bus.req = 8'b0000_1000;
        tick();
        check_grant("late_hand", 3);

        // Request withdrawn before grant: 5 raised then dropped while 3 holds.
        bus.req = 8'b0010_1000;
        tick();
        check_grant("wd_hold", 3);
        bus.req = 8'b0000_1000;
        tick();
        bus.req = 8'b0000_0000;
        tick();
        check_none("wd_rel");
        // ptr stays at 4: 2 and 4 request -> 4 wins.
        bus.req = 8'b0001_0100;
        tick();
        check_grant("wd_ptr", 4);
        bus.req = 8'h00;
        tick();
        check_none("wd_idle");

        // Requesters 0 and 3 both held high.
        do_reset(8'h00);
        bus.req = 8'b0000_1001;
        for (int c = 0; c < 9; c++) begin
            tick();
`ifdef RR_ARB_TIMEOUT_EN
            check_grant($sformatf("tmo%0d", c), (((c / 4) % 2) == 1) ? 3 : 0);
`else
            check_grant($sformatf("tmo%0d", c), 0);
`endif
        end
        bus.req = 8'h00;
        tick();
        check_none("tmo_rel");

        // Asynchronous reset mid-grant.
        bus.req = 8'h20;
        tick();
        check_grant("ar5", 5);
        rst_n = 1'b0;
        #2;
        check_eq("ar.gnt",   32'(bus.gnt),       32'd0);
        check_eq("ar.idx",   32'(bus.gnt_idx),   32'd0);
        check_eq("ar.valid", 32'(bus.gnt_valid), 32'd0);
        bus.req = 8'hFF;
        #1;
        rst_n = 1'b1;
        tick();
        check_grant("ar_rel", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
